imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, multi-mode immediate extender with a valid/ready pipeline of configurable depth. It sits between instruction decode and the ALU-B / PC-adder operand muxes of the multi-cycle CPU. It produces zero-extended, sign-extended, upper-immediate and branch-offset values. Back-pressure from the consuming stage holds results stably in the pipeline, and a flush discards in-flight immediates on a taken branch or exception.

## Interface
Parameters:
- IN_W, 16, immediate field width; legal range is 2 or more.
- OUT_W, 32, extended result width; must satisfy OUT_W > IN_W.
- DEPTH, 2, number of pipeline register stages; legal range is 1..4.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears all pipeline state.
- Flush  in  1  synchronous; discards all in-flight entries.
- ExtMode  in  2  operation select: 00 ZERO, 01 SIGN, 10 LUI, 11 BRANCH.
- ime  in  IN_W  immediate field.
- in_valid  in  1  ime/ExtMode are valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- exten  out  OUT_W  extended result from the last stage.
- out_valid  out  1  exten is valid.
- out_ready  in  1  consumer accepts exten this cycle.

## Operation
- Extension is computed combinationally on input and captured into stage 0. Stages 1..DEPTH-1 delay the value only.
- ZERO: zeros in the upper OUT_W-IN_W bits, then ime.
- SIGN: ime[IN_W-1] replicated into the upper bits, then ime.
- LUI: ime placed in the upper bits, with OUT_W-IN_W zeros below. If OUT_W-IN_W < IN_W, the upper bits of ime are truncated; only the low OUT_W bits are kept.
- BRANCH: the SIGN result shifted left by 2. The top 2 bits are dropped and the low 2 bits are 0.
- Each stage k holds a valid bit v[k] and a data register.
- Stage k loads when !v[k], or when stage k+1 loads. For the last stage, "stage k+1 loads" means out_ready.
- in_ready equals the stage-0 load condition, gated by !Flush. The ready chain is combinational.
- Acceptance happens on an edge where in_valid && in_ready. Transfer happens on an edge where out_valid && out_ready.
- Entries leave in acceptance order; none are lost or duplicated.
- Data registers load only on an accepted or advancing entry. exten holds its value while out_valid && !out_ready, and keeps its last value when the pipeline empties.
- Priority is Reset > Flush > normal operation.
- Reset: clears all v[k] and all data registers to 0.
- Flush: clears all v[k]. Data registers are untouched, and no input is accepted in that cycle.

## Timing
- Reset values: out_valid=0, exten=0, in_ready=1 in the first cycle after Reset deasserts. While Reset is high, in_ready=0.
- Latency is DEPTH cycles from the acceptance edge to out_valid=1, provided no stall.
- Throughput is 1 entry per cycle with out_ready held at 1.
- Capacity is DEPTH entries. With out_ready=0, in_ready falls after DEPTH acceptances.
- When the pipeline is full and out_ready=1, a new input is accepted in the same cycle the output transfers. There is no bubble.
- Flush or Reset asserted mid-stream takes effect at that edge. The next cycle has out_valid=0, and in_ready=1 if the reset/flush input has dropped.
- Flush coinciding with in_valid: the input is dropped, with in_ready=0 in that cycle.
- Flush coinciding with a transfer: the consumer has already sampled the entry, which counts as delivered.

## Structure
- Shared package ext_pkg holds:
  - localparams EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BRANCH (2-bit codes);
  - function ext_calc(mode, ime), parametrised via the module's IN_W/OUT_W.
- Sub-module ext_stage: one valid/data register slice with load/clear inputs. It is instantiated DEPTH times in a generate loop, and the ready chain is wired in the top module.

## Test plan
- Modes, with IN_W=16, OUT_W=32, DEPTH=2, out_ready=1:
  - ime=8001h: SIGN gives exten=FFFF8001h two cycles after acceptance; ZERO gives 00008001h.
  - LUI 1234h gives 12340000h; BRANCH FFFFh gives FFFFFFFCh; BRANCH 7FFFh gives 0001FFFCh.
- Back-pressure:
  - Stimulus: 4 back-to-back inputs A..D, out_ready=0 for 3 cycles.
  - Response: in_ready drops after A,B are accepted; exten=A is stable throughout the stall; once out_ready rises, A,B,C,D are delivered in order with no gaps.
- Full-pipe pass-through:
  - Stimulus: pipeline full, out_ready=1, in_valid=1 continuously.
  - Response: one transfer and one acceptance every cycle; in_ready stays 1.
- Flush:
  - Stimulus: full pipeline, with Flush and in_valid asserted in the same cycle.
  - Response: in_ready=0 that cycle; next cycle out_valid=0 and in_ready=1; no flushed or dropped entry ever appears.
- Reset and depth:
  - Stimulus: Reset mid-stream; then variants DEPTH=1 and DEPTH=4.
  - Response: after Reset, out_valid=0 and exten=0; DEPTH=1 latency is 1 cycle with capacity 1; DEPTH=4 latency is 4 cycles with capacity 4.

Source files
------------

// File: rtl/ext_pkg.sv
// Extension mode codes and the shared immediate-extension function used by
// the operand pipeline.
package ext_pkg;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_LUI    = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    // Widest result the function can produce; callers truncate to their OUT_W.
    localparam int EXT_MAX_W = 64;

    function automatic logic [EXT_MAX_W-1:0] ext_calc(
        input logic [1:0]           mode,
        input logic [EXT_MAX_W-1:0] ime,
        input int                   in_w,
        input int                   out_w
    );
        logic [EXT_MAX_W-1:0] zx;
        logic [EXT_MAX_W-1:0] sx;
        logic                 sgn;
        sgn = 1'b0;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i == in_w - 1) sgn = ime[i];
        end
        for (int i = 0; i < EXT_MAX_W; i++) begin
            zx[i] = (i < in_w) ? ime[i] : 1'b0;
            sx[i] = (i < in_w) ? ime[i] : sgn;
        end
        case (mode)
            EXT_ZERO: ext_calc = zx;
            EXT_SIGN: ext_calc = sx;
            EXT_LUI:  ext_calc = zx << (out_w - in_w);
            default:  ext_calc = sx << 2;
        endcase
    endfunction

endpackage

// File: rtl/ext_stage.sv
// One valid/data slice of the immediate pipeline; data only moves with a
// valid entry so the last stage holds its value once the pipe drains.
module ext_stage #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d = vld_i;
            if (vld_i) data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding the ALU-B / PC-adder muxes through a DEPTH-stage
// valid/ready pipeline with flush.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic [1:0]       ExtMode,
    input  logic [IN_W-1:0]  ime,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] exten,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [DEPTH:0]   load;
    logic [DEPTH-1:0] vld;
    logic [OUT_W-1:0] data [DEPTH];
    logic [OUT_W-1:0] ext_d;

    assign ext_d = OUT_W'(ext_calc(ExtMode, EXT_MAX_W'(ime), IN_W, OUT_W));

    // Ready chain: a stage can load when empty or when the stage ahead moves.
    always_comb begin
        load        = '0;
        load[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            load[k] = !vld[k] || load[k+1];
        end
    end

    assign in_ready = load[0] && !Flush && !Reset;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             vld_in;
        logic [OUT_W-1:0] data_in;
        if (k == 0) begin : g_head
            assign vld_in  = in_valid && in_ready;
            assign data_in = ext_d;
        end else begin : g_tail
            assign vld_in  = vld[k-1];
            assign data_in = data[k-1];
        end
        ext_stage #(.W(OUT_W)) u_stage (
            .clk_i  (CLK),
            .rst_i  (Reset),
            .clr_i  (Flush),
            .load_i (load[k]),
            .vld_i  (vld_in),
            .data_i (data_in),
            .vld_o  (vld[k]),
            .data_o (data[k])
        );
    end

    assign exten     = data[DEPTH-1];
    assign out_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three depths (1, 2, 4) share one stimulus stream
// and are compared each cycle against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        CLK;
    logic        Reset;
    logic        Flush;
    logic [1:0]  ExtMode;
    logic [15:0] ime;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [31:0] ex [3];

    int checks;
    int errors;
    int cyc;

    // Reference model: per instance a FIFO of (value, acceptance cycle).
    logic [31:0] md [3][4];
    int          ma [3][4];
    int          mc [3];
    logic [31:0] mlast [3];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) u_d1 (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .ExtMode(ExtMode), .ime(ime),
        .in_valid(in_valid), .in_ready(rdy[0]), .exten(ex[0]), .out_valid(ov[0]),
        .out_ready(out_ready));
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) u_d2 (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .ExtMode(ExtMode), .ime(ime),
        .in_valid(in_valid), .in_ready(rdy[1]), .exten(ex[1]), .out_valid(ov[1]),
        .out_ready(out_ready));
    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) u_d4 (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .ExtMode(ExtMode), .ime(ime),
        .in_valid(in_valid), .in_ready(rdy[2]), .exten(ex[2]), .out_valid(ov[2]),
        .out_ready(out_ready));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int dep(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] v);
        logic signed [31:0] s;
        s = 32'($signed(v));
        case (m)
            2'b00:   return {16'h0000, v};
            2'b01:   return s;
            2'b10:   return {v, 16'h0000};
            default: return s * 32'sd4;
        endcase
    endfunction

    // Called at a negedge with inputs already applied.
    task automatic step();
        logic [2:0] acc;
        logic [2:0] xfr;
        logic       exp_rdy;
        logic       exp_ov;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_rdy = !Reset && !Flush && ((mc[i] < dep(i)) || out_ready);
            exp_ov  = (mc[i] > 0) && (cyc >= ma[i][0] + dep(i) - 1);
            if (exp_ov) mlast[i] = md[i][0];
            chk_eq($sformatf("in_ready[d%0d]", dep(i)), 32'(rdy[i]), 32'(exp_rdy));
            chk_eq($sformatf("out_valid[d%0d]", dep(i)), 32'(ov[i]), 32'(exp_ov));
            chk_eq($sformatf("exten[d%0d]", dep(i)), ex[i], mlast[i]);
            acc[i] = in_valid && exp_rdy;
            xfr[i] = exp_ov && out_ready;
        end
        @(posedge CLK);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                mc[i]    = 0;
                mlast[i] = '0;
            end else begin
                if (xfr[i]) begin
                    for (int k = 0; k < 3; k++) begin
                        md[i][k] = md[i][k+1];
                        ma[i][k] = ma[i][k+1];
                    end
                    mc[i]--;
                end
                if (Flush) begin
                    mc[i] = 0;
                end else if (acc[i]) begin
                    md[i][mc[i]] = ref_ext(ExtMode, ime);
                    ma[i][mc[i]] = cyc;
                    mc[i]++;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic rand_in();
        ExtMode = 2'($urandom_range(0, 3));
        ime     = 16'($urandom);
    endtask

    logic [1:0]  dmode [5];
    logic [15:0] dime  [5];
    logic [31:0] dexp  [5];

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mlast[i] = '0;
        end
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ExtMode = 2'b00; ime = '0;
        dmode = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
        dime  = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
        dexp  = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        step();
        Reset = 1'b0; out_ready = 1'b1;
        step();

        // Directed modes with latency per depth
        for (int v = 0; v < 5; v++) begin
            ExtMode = dmode[v]; ime = dime[v]; in_valid = 1'b1;
            step();
            chk_eq("lat_d1_valid", 32'(ov[0]), 32'd1);
            chk_eq("lat_d1_data", ex[0], dexp[v]);
            in_valid = 1'b0;
            step();
            chk_eq("lat_d2_valid", 32'(ov[1]), 32'd1);
            chk_eq("lat_d2_data", ex[1], dexp[v]);
            chk_eq("lat_d4_early", 32'(ov[2]), 32'd0);
            step();
            step();
            chk_eq("lat_d4_valid", 32'(ov[2]), 32'd1);
            chk_eq("lat_d4_data", ex[2], dexp[v]);
        end
        repeat (4) step();

        // Back-pressure: capacity equals depth, output held stable
        out_ready = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            rand_in();
            step();
            for (int i = 0; i < 3; i++)
                chk_eq($sformatf("cap_rdy[d%0d]", dep(i)), 32'(rdy[i]), 32'(j < dep(i)));
        end
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (6) step();

        // Full-pipe pass-through
        in_valid = 1'b1;
        for (int j = 0; j < 20; j++) begin
            rand_in();
            step();
            chk_eq("pass_rdy", 32'(rdy), 32'h7);
        end

        // Flush with coincident input
        out_ready = 1'b0;
        repeat (4) begin rand_in(); step(); end
        Flush = 1'b1; rand_in();
        #1;
        chk_eq("flush_rdy", 32'(rdy), 32'h0);
        step();
        Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk_eq("post_flush_valid", 32'(ov), 32'h0);
        chk_eq("post_flush_rdy", 32'(rdy), 32'h7);
        repeat (3) step();

        // Reset mid-stream
        in_valid = 1'b1;
        repeat (6) begin rand_in(); out_ready = 1'($urandom_range(0, 1)); step(); end
        Reset = 1'b1;
        step();
        Reset = 1'b0; in_valid = 1'b0;
        #1;
        chk_eq("post_reset_valid", 32'(ov), 32'h0);
        chk_eq("post_reset_rdy", 32'(rdy), 32'h7);
        for (int i = 0; i < 3; i++)
            chk_eq($sformatf("post_reset_exten[d%0d]", dep(i)), ex[i], 32'h0);
        step();

        // Randomised traffic with occasional flush and reset
        for (int j = 0; j < 400; j++) begin
            rand_in();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            Flush     = ($urandom_range(0, 99) < 3);
            Reset     = ($urandom_range(0, 99) < 2);
            step();
        end
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
